// File: rtl/dbus_responder_if.sv
// Core data-bus request/response types and the interface bundling them.
// The core side uses the master modport; the responder uses the slave modport.
package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

interface dbus_responder_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_responder.sv
// Memory-backed data-bus responder: one outstanding request, fixed latency, byte-lane writes.
// Optional macro DBUS_RESP_RANDOM_DELAY_EN adds 0..3 LFSR-chosen extra wait cycles per request.
module dbus_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    dbus_responder_if.slave   bus,
    output logic [31:0]       n_reads,
    output logic [31:0]       n_writes,
    output logic              oob
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        is_read_q, is_read_d;
    logic [31:0] n_reads_q, n_reads_d;
    logic [31:0] n_writes_q, n_writes_d;
    logic        oob_q, oob_d;

    logic [63:0] mem [MEM_WORDS];

    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             req_is_read;
    logic             accept;
    logic             wr_en;
    logic             addr_ok;
    logic             data_ok;
    logic [63:0]      resp_data;
    logic [4:0]       extra;
    logic [4:0]       wait_len;
    logic             unused_bits;

    assign idx          = bus.dreq.addr[3 +: IDX_W];
    assign out_of_range = |bus.dreq.addr[63:3+IDX_W];
    assign req_is_read  = (bus.dreq.strobe == 8'h00);
    assign unused_bits  = ^{bus.dreq.size, bus.dreq.addr[2:0]};

`ifdef DBUS_RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign extra  = {3'b000, lfsr_q[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign extra = 5'd0;
`endif

    assign wait_len = LAT_M1 + extra;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        is_read_d  = is_read_q;
        n_reads_d  = n_reads_q;
        n_writes_d = n_writes_q;
        oob_d      = oob_q;
        addr_ok    = 1'b0;
        data_ok    = 1'b0;
        resp_data  = 64'd0;
        accept     = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so nothing is accepted (or written) while held in reset.
                addr_ok = bus.dreq.valid & reset;
                accept  = addr_ok;
                if (accept) begin
                    is_read_d = req_is_read;
                    rdata_d   = (req_is_read && !out_of_range) ? mem[idx] : 64'd0;
                    oob_d     = oob_q | out_of_range;
                    wr_en     = !req_is_read && !out_of_range;
                    if (wait_len == 5'd0) begin
                        state_d = RESP;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = wait_len;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 5'd1) begin
                    state_d = RESP;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            RESP: begin
                data_ok   = 1'b1;
                resp_data = is_read_q ? rdata_q : 64'd0;
                if (is_read_q) begin
                    n_reads_d = n_reads_q + 32'd1;
                end else begin
                    n_writes_d = n_writes_q + 32'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            rdata_q    <= 64'd0;
            is_read_q  <= 1'b0;
            n_reads_q  <= 32'd0;
            n_writes_q <= 32'd0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            is_read_q  <= is_read_d;
            n_reads_q  <= n_reads_d;
            n_writes_q <= n_writes_d;
            oob_q      <= oob_d;
        end
    end

    // Backing store has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en && bus.dreq.strobe[i]) begin
                mem[idx][8*i +: 8] <= bus.dreq.data[8*i +: 8];
            end
        end
    end

    assign bus.dresp = {addr_ok, data_ok, resp_data};
    assign n_reads   = n_reads_q;
    assign n_writes  = n_writes_q;
    assign oob       = oob_q;

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 The block SHALL be parameterised by MEM_WORDS, default 1024, giving the backing store depth in 64-bit words (power of two, at least 2).
REQ-002 The block SHALL be parameterised by LATENCY, default 2, giving the cycles from request acceptance to data_ok (legal range 1..15).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; the block is in reset while reset is 0.
REQ-005 Port dreq, input, dbus_req_t: the core request, with fields valid, addr (64), size, strobe (8), data (64).
REQ-006 Port dresp, output, dbus_resp_t: the response, with fields addr_ok, data_ok, data (64).
REQ-007 Port n_reads, output, 32: count of completed reads, wrapping modulo 2^32.
REQ-008 Port n_writes, output, 32: count of completed writes, wrapping modulo 2^32.
REQ-009 Port oob, output, 1: sticky flag, set when any out-of-range address is accepted.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-011 In IDLE, dresp.addr_ok SHALL equal dreq.valid combinationally, and a cycle where both are 1 is the accept cycle.
REQ-012 The FSM SHALL leave IDLE only on an accept cycle.
REQ-013 Outside IDLE, dresp.addr_ok SHALL be 0.
REQ-014 A request SHALL be a write when strobe is not 0, and a read otherwise.
REQ-015 The word index SHALL be addr[3+log2(MEM_WORDS)-1:3]; addr[2:0] and size SHALL NOT affect indexing.
REQ-016 An address is out of range when any addr bit above the index field is 1.
REQ-017 A write SHALL commit byte lanes where strobe[i] is 1 (data[8i+7:8i]) at the accept edge; other lanes are unchanged.
REQ-018 A read SHALL capture the full 64-bit word at the accept edge into a response register.
REQ-019 An out-of-range write SHALL be dropped; an out-of-range read SHALL return 0.
REQ-020 Any out-of-range accept SHALL set oob.
REQ-021 dresp.data_ok SHALL be 1 for exactly one cycle (RESP), LATENCY cycles after the accept cycle; WAIT lasts LATENCY-1 cycles.
REQ-022 The next state after RESP SHALL be IDLE; the earliest next accept is the cycle after data_ok.
REQ-023 dresp.data SHALL hold the captured read word while data_ok is 1, and 0 for writes and in all other cycles.
REQ-024 n_reads or n_writes SHALL increment at the RESP edge of the completed transaction.
REQ-025 An accepted transaction SHALL complete even if dreq.valid falls before data_ok; the response is still produced and counted.
REQ-026 dreq fields SHALL be ignored outside the accept cycle.
REQ-027 A read accepted after a write to the same word SHALL return the written data.

Reset
REQ-028 While reset is 0: state SHALL be IDLE, addr_ok/data_ok 0, dresp.data 0, n_reads/n_writes 0, oob 0, and the wait counter 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no data_ok and no counter update; a write already committed at its accept edge persists.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With DBUS_RESP_RANDOM_DELAY_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1, advancing every cycle out of reset) SHALL add its low 2 bits (0..3) as extra WAIT cycles, sampled at accept.
REQ-032 Without DBUS_RESP_RANDOM_DELAY_EN, latency SHALL be exactly LATENCY and no LFSR SHALL exist.

Verification
REQ-033 LATENCY=2: write addr 0x40, strobe 0xFF, data 0x1122334455667788, then read 0x40 -> data_ok two cycles after each accept; read data 0x1122334455667788; n_writes=1, n_reads=1.
REQ-034 Partial write: after the word holds 0x1122334455667788, write strobe 0x0F, data 0xAAAAAAAABBBBBBBB, then read -> 0x11223344BBBBBBBB.
REQ-035 With MEM_WORDS=1024, read addr 0x2000 -> data 0 and oob=1; a write to 0x2000 leaves word 0 unchanged.
REQ-036 Drop valid one cycle after accept -> data_ok still pulses at accept+LATENCY, and the counter increments.
REQ-037 Pull reset low during WAIT -> data_ok never asserts, counters are 0, addr_ok returns with the next valid after release.
REQ-038 Macro defined: 100 back-to-back reads -> every latency is in [LATENCY, LATENCY+3] and all data is correct.
